// File: rtl/reset_sequencer.sv
// Reset initiator: drives one shared active-low reset pulse to a set of
// downstream blocks, waits for all of them to report initialized, retries on
// timeout and reports ready, timeout or lost initialization.
module reset_sequencer #(
  parameter int unsigned NUM_TARGETS    = 4,
  parameter int unsigned PULSE_CYCLES   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start_i,
  input  logic [NUM_TARGETS-1:0] target_initialized_i,
  output logic                   target_resetn_o,
  output logic                   busy_o,
  output logic                   all_ready_o,
  output logic                   timed_out_o,
  output logic                   lost_init_o,
  output logic [NUM_TARGETS-1:0] fail_mask_o,
  output logic [3:0]             retry_count_o
);

  localparam logic [1:0] StPulse = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StReady = 2'd2;
  localparam logic [1:0] StFail  = 2'd3;

  localparam logic [15:0] PulseLast   = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RetryMax    = 4'(MAX_RETRIES);

  logic [1:0]             state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   trn_q, trn_d;
  logic                   busy_q, busy_d;
  logic                   all_ready_q, all_ready_d;
  logic                   timed_out_q, timed_out_d;
  logic                   lost_init_q, lost_init_d;
  logic [NUM_TARGETS-1:0] fail_mask_q, fail_mask_d;
  logic [3:0]             retry_q, retry_d;

  logic all_init;
  assign all_init = &target_initialized_i;

  // Next-state and next-output decode; every output is a flop so no input
  // reaches an output combinationally.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trn_d       = trn_q;
    busy_d      = busy_q;
    all_ready_d = all_ready_q;
    timed_out_d = timed_out_q;
    lost_init_d = lost_init_q;
    fail_mask_d = fail_mask_q;
    retry_d     = retry_q;

    case (state_q)
      StPulse: begin
        if (cnt_q == PulseLast) begin
          state_d = StWait;
          cnt_d   = '0;
          trn_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StWait: begin
        // Ready wins even on the final timeout cycle.
        if (all_init) begin
          state_d     = StReady;
          cnt_d       = '0;
          all_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else if (cnt_q == TimeoutLast) begin
          // Overwritten on every timeout so it reflects the last failing set.
          fail_mask_d = ~target_initialized_i;
          cnt_d       = '0;
          if (retry_q == RetryMax) begin
            state_d     = StFail;
            timed_out_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            state_d = StPulse;
            retry_d = retry_q + 4'd1;
            trn_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StReady: begin
        // Loss of initialization outranks a start request.
        if (!all_init) begin
          state_d     = StFail;
          cnt_d       = '0;
          all_ready_d = 1'b0;
          lost_init_d = 1'b1;
          fail_mask_d = ~target_initialized_i;
        end else if (start_i) begin
          state_d     = StPulse;
          cnt_d       = '0;
          trn_d       = 1'b0;
          busy_d      = 1'b1;
          all_ready_d = 1'b0;
          retry_d     = '0;
          fail_mask_d = '0;
        end
      end

      StFail: begin
        if (start_i) begin
          state_d     = StPulse;
          cnt_d       = '0;
          trn_d       = 1'b0;
          busy_d      = 1'b1;
          timed_out_d = 1'b0;
          lost_init_d = 1'b0;
          fail_mask_d = '0;
          retry_d     = '0;
        end
      end

      default: begin
        state_d = StPulse;
        cnt_d   = '0;
        trn_d   = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StPulse;
      cnt_q       <= '0;
      trn_q       <= 1'b0;
      busy_q      <= 1'b1;
      all_ready_q <= 1'b0;
      timed_out_q <= 1'b0;
      lost_init_q <= 1'b0;
      fail_mask_q <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trn_q       <= trn_d;
      busy_q      <= busy_d;
      all_ready_q <= all_ready_d;
      timed_out_q <= timed_out_d;
      lost_init_q <= lost_init_d;
      fail_mask_q <= fail_mask_d;
      retry_q     <= retry_d;
    end
  end

  assign target_resetn_o = trn_q;
  assign busy_o          = busy_q;
  assign all_ready_o     = all_ready_q;
  assign timed_out_o     = timed_out_q;
  assign lost_init_o     = lost_init_q;
  assign fail_mask_o     = fail_mask_q;
  assign retry_count_o   = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus a randomized run checked
// against a remaining-time reference model.
module tb_reset_sequencer;

  localparam int N = 2;
  localparam int P = 4;
  localparam int T = 20;
  localparam int R = 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] ti = '0;
  logic         trn, busy, all_ready, timed_out, lost_init;
  logic [N-1:0] fail_mask;
  logic [3:0]   retry_count;

  int n_checks = 0;
  int n_errors = 0;

  reset_sequencer #(
    .NUM_TARGETS   (N),
    .PULSE_CYCLES  (P),
    .TIMEOUT_CYCLES(T),
    .MAX_RETRIES   (R)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .start_i             (start),
    .target_initialized_i(ti),
    .target_resetn_o     (trn),
    .busy_o              (busy),
    .all_ready_o         (all_ready),
    .timed_out_o         (timed_out),
    .lost_init_o         (lost_init),
    .fail_mask_o         (fail_mask),
    .retry_count_o       (retry_count)
  );

  always #5 clk = ~clk;

  // Reference model: tracks remaining pulse cycles and remaining wait budget.
  typedef struct {
    int       pulse_left;
    int       wait_left;
    bit       ready;
    bit       to;
    bit       li;
    bit [N-1:0] mask;
    int       retries;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, logic rn, logic st, logic [N-1:0] in);
    model_t n = c;
    bit ok = (in == {N{1'b1}});
    if (!rn) begin
      n.pulse_left = P; n.wait_left = 0; n.ready = 0; n.to = 0; n.li = 0;
      n.mask = '0; n.retries = 0;
    end else if (c.pulse_left > 0) begin
      n.pulse_left = c.pulse_left - 1;
      if (n.pulse_left == 0) n.wait_left = T;
    end else if (c.wait_left > 0) begin
      if (ok) begin
        n.wait_left = 0; n.ready = 1;
      end else if (c.wait_left == 1) begin
        n.mask = ~in;
        n.wait_left = 0;
        if (c.retries == R) n.to = 1;
        else begin
          n.retries = c.retries + 1; n.pulse_left = P;
        end
      end else begin
        n.wait_left = c.wait_left - 1;
      end
    end else if (c.ready) begin
      if (!ok) begin
        n.ready = 0; n.li = 1; n.mask = ~in;
      end else if (st) begin
        n.ready = 0; n.pulse_left = P; n.retries = 0; n.mask = '0;
      end
    end else if (st) begin
      n.to = 0; n.li = 0; n.mask = '0; n.retries = 0; n.pulse_left = P;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, resetn, start, ti);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] init);
    resetn = 1'b0;
    start  = 1'b0;
    ti     = init;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    int low = 0;
    resetn = 1'b0;
    ti = '0;
    tick();
    tick();
    n_checks++;
    if ({trn, busy, all_ready, timed_out, lost_init, fail_mask, retry_count} !== 11'b01000000000)
    begin
      n_errors++;
      $display("FAIL reset_state got=%b want=01000000000",
               {trn, busy, all_ready, timed_out, lost_init, fail_mask, retry_count});
    end
    resetn = 1'b1;
    while (trn === 1'b0 && low < 50) begin
      low++;
      tick();
    end
    n_checks++;
    if (low != P) begin
      n_errors++;
      $display("FAIL reset_pulse_len got=%0d want=%0d", low, P);
    end
    // Now in WAIT cycle 1; targets come up on WAIT cycle 10.
    for (int i = 1; i < 10; i++) tick();
    n_checks++;
    if (busy !== 1'b1 || all_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL wait_before_ready got busy=%b ready=%b want busy=1 ready=0",
               busy, all_ready);
    end
    ti = 2'b11;
    tick();
    n_checks++;
    if ({trn, busy, all_ready, timed_out, retry_count} !== 8'b10100000) begin
      n_errors++;
      $display("FAIL ready_after_init got trn,busy,rdy,to,retry=%b want=10100000",
               {trn, busy, all_ready, timed_out, retry_count});
    end
  endtask

  task automatic test_timeout();
    int low = 0;
    int waitc = 0;
    do_reset(2'b01);
    while (busy === 1'b1 && (low + waitc) < 400) begin
      if (trn === 1'b0) low++;
      else waitc++;
      tick();
    end
    n_checks++;
    if (low != 3 * P || waitc != 3 * T) begin
      n_errors++;
      $display("FAIL timeout_durations got low=%0d wait=%0d want low=%0d wait=%0d",
               low, waitc, 3 * P, 3 * T);
    end
    n_checks++;
    if ({trn, busy, all_ready, timed_out, lost_init, fail_mask, retry_count} !== 11'b10010100010)
    begin
      n_errors++;
      $display("FAIL timeout_final got=%b want=10010100010",
               {trn, busy, all_ready, timed_out, lost_init, fail_mask, retry_count});
    end
  endtask

  task automatic test_late_ready();
    do_reset(2'b00);
    // Pulse, full wait, retry pulse, then 19 wait cycles: now at counter 19.
    for (int i = 0; i < P + T + P + (T - 1); i++) tick();
    n_checks++;
    if ({trn, busy, fail_mask, retry_count} !== 8'b11110001) begin
      n_errors++;
      $display("FAIL late_last_wait got trn,busy,mask,retry=%b want=11110001",
               {trn, busy, fail_mask, retry_count});
    end
    ti = 2'b11;
    tick();
    n_checks++;
    if ({busy, all_ready, timed_out, lost_init, retry_count} !== 8'b01000001) begin
      n_errors++;
      $display("FAIL late_ready got busy,rdy,to,li,retry=%b want=01000001",
               {busy, all_ready, timed_out, lost_init, retry_count});
    end
  endtask

  task automatic test_lost_init();
    int low = 0;
    ti = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if ({trn, busy, all_ready, timed_out, lost_init, fail_mask} !== 7'b1000101) begin
      n_errors++;
      $display("FAIL lost_init got trn,busy,rdy,to,li,mask=%b want=1000101",
               {trn, busy, all_ready, timed_out, lost_init, fail_mask});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({trn, busy, all_ready, timed_out, lost_init, fail_mask, retry_count} !== 11'b01000000000)
    begin
      n_errors++;
      $display("FAIL restart_from_fail got=%b want=01000000000",
               {trn, busy, all_ready, timed_out, lost_init, fail_mask, retry_count});
    end
    while (trn === 1'b0 && low < 50) begin
      low++;
      tick();
    end
    n_checks++;
    if (low != P) begin
      n_errors++;
      $display("FAIL restart_pulse_len got=%0d want=%0d", low, P);
    end
  endtask

  task automatic test_wait_start_and_reset();
    int low = 0;
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({trn, busy, all_ready} !== 3'b110) begin
      n_errors++;
      $display("FAIL start_in_wait got trn,busy,rdy=%b want=110", {trn, busy, all_ready});
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_checks++;
    if ({trn, busy, all_ready, timed_out, lost_init, retry_count} !== 9'b010000000) begin
      n_errors++;
      $display("FAIL mid_wait_reset got=%b want=010000000",
               {trn, busy, all_ready, timed_out, lost_init, retry_count});
    end
    while (trn === 1'b0 && low < 50) begin
      low++;
      tick();
    end
    n_checks++;
    if (low != P) begin
      n_errors++;
      $display("FAIL mid_wait_reset_pulse got=%0d want=%0d", low, P);
    end
  endtask

  task automatic test_random();
    logic [10:0] got, exp;
    int flags;
    do_reset(2'b00);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ((cyc / 150) % 2 == 0) ti = ($urandom_range(0, 15) == 0) ? N'($urandom) : 2'b11;
      else ti = N'($urandom);
      start = ($urandom_range(0, 7) == 0);
      resetn = ($urandom_range(0, 499) != 0);
      tick();
      exp = {(m.pulse_left == 0), (m.pulse_left > 0 || m.wait_left > 0), m.ready, m.to, m.li,
             m.mask, 4'(m.retries)};
      got = {trn, busy, all_ready, timed_out, lost_init, fail_mask, retry_count};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, got, exp);
      end
      flags = int'(busy) + int'(all_ready) + int'(timed_out | lost_init);
      n_checks++;
      if (flags != 1 || (timed_out && lost_init) || (!trn && !busy)) begin
        n_errors++;
        $display("FAIL invariant cyc=%0d got busy,rdy,to,li,trn=%b want one-hot/legal", cyc,
                 {busy, all_ready, timed_out, lost_init, trn});
      end
    end
    resetn = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_timeout();
    test_late_ready();
    test_lost_init();
    test_wait_start_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
